mips_mmio: RTL and testbench

Memory-side bus block sitting directly downstream of the multicycle `mips` core's single memory port (`mem_addr`, `mem_wr_data`, `mem_wr_ena`, `mem_rd_data`). It decodes each access and routes it either to the backing instruction/data RAM or to a small memory-mapped peripheral set. The peripherals are a LED register, a free-running cycle timer and a FIFO-buffered 8N1 UART transmitter. The core has no stall input, so all read data returns combinationally in the same cycle as the address.

---
 rtl/mips_mmio.sv | 218 +++++++++++++++++++++
 tb/tb_mips_mmio.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mips_mmio.sv
// Memory-side bus block for the multicycle mips core: routes each access to RAM or to
// the LED register, cycle timer, and FIFO-buffered 8N1 UART transmitter.
module mips_mmio #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8,
  parameter int LED_W        = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wr_data,
  input  logic             mem_wr_ena,
  output logic [31:0]      mem_rd_data,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wr_data,
  output logic             ram_wr_ena,
  input  logic [31:0]      ram_rd_data,
  output logic [LED_W-1:0] leds,
  output logic             uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [29:0]   A_LED     = 30'h2000_0000;
  localparam logic [29:0]   A_TMR     = 30'h2000_0001;
  localparam logic [29:0]   A_TXD     = 30'h2000_0002;
  localparam logic [29:0]   A_STS     = 30'h2000_0003;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [LED_W-1:0] r_leds;
  logic [31:0]      r_timer;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  state_t           r_state;
  logic [BW-1:0]    r_baud;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;

  logic          w_sel_led, w_sel_tmr, w_sel_txd, w_sel_sts;
  logic          w_push, w_pop, w_full, w_empty, w_push_ok;
  logic [31:0]   w_status;
  state_t        w_state_n;
  logic [BW-1:0] w_baud_n;
  logic [2:0]    w_bit_n;
  logic [7:0]    w_shift_n;
  logic          w_tx_n;

  assign ram_addr    = mem_addr;
  assign ram_wr_data = mem_wr_data;
  assign ram_wr_ena  = mem_wr_ena & ~mem_addr[31];
  assign leds        = r_leds;
  assign uart_tx     = r_tx;

  // Full-word decode: aliases of the peripheral window read as zero.
  assign w_sel_led = mem_addr[31:2] == A_LED;
  assign w_sel_tmr = mem_addr[31:2] == A_TMR;
  assign w_sel_txd = mem_addr[31:2] == A_TXD;
  assign w_sel_sts = mem_addr[31:2] == A_STS;

  assign w_full    = r_count == CNT_FULL;
  assign w_empty   = r_count == '0;
  assign w_push    = mem_wr_ena & w_sel_txd;
  assign w_push_ok = w_push & ~w_full;

  always_comb begin
    w_status        = 32'd0;
    w_status[0]     = w_full;
    w_status[1]     = w_empty;
    w_status[2]     = r_state != S_IDLE;
    w_status[3]     = r_ovf;
    w_status[15:8]  = 8'(r_count);
  end

  always_comb begin
    mem_rd_data = 32'd0;
    if (!mem_addr[31]) begin
      mem_rd_data = ram_rd_data;
    end else if (w_sel_led) begin
      mem_rd_data = 32'(r_leds);
    end else if (w_sel_tmr) begin
      mem_rd_data = r_timer;
    end else if (w_sel_sts) begin
      mem_rd_data = w_status;
    end else begin
      mem_rd_data = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_leds  <= '0;
      r_timer <= 32'd0;
    end else begin
      if (mem_wr_ena && w_sel_led) r_leds <= mem_wr_data[LED_W-1:0];
      if (mem_wr_ena && w_sel_tmr) r_timer <= mem_wr_data;
      else                         r_timer <= r_timer + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= mem_wr_data[7:0];
  end

  // A push into a full FIFO is lost and latches overflow, regardless of a same-cycle pop.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full)            r_ovf <= 1'b1;
      else if (mem_wr_ena && w_sel_sts) r_ovf <= 1'b0;
      else                              r_ovf <= r_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
    end
  end

  // w_tx_n is the line level for the state being entered, so uart_tx stays a flop output.
  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_tx_n    = 1'b1;
    w_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_n = '0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = r_mem[r_rd_ptr];
          w_state_n = S_START;
          w_tx_n    = 1'b0;
        end else begin
          w_tx_n = 1'b1;
        end
      end
      S_START: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_n  = '0;
          w_bit_n   = 3'd0;
          w_state_n = S_DATA;
          w_tx_n    = r_shift[0];
        end else begin
          w_baud_n = r_baud + BW'(1);
          w_tx_n   = 1'b0;
        end
      end
      S_DATA: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) begin
            w_state_n = S_STOP;
            w_tx_n    = 1'b1;
          end else begin
            w_bit_n   = r_bit + 3'd1;
            w_shift_n = {1'b0, r_shift[7:1]};
            w_tx_n    = r_shift[1];
          end
        end else begin
          w_baud_n = r_baud + BW'(1);
          w_tx_n   = r_shift[0];
        end
      end
      S_STOP: begin
        w_tx_n = 1'b1;
        if (r_baud == BAUD_LAST) begin
          w_baud_n  = '0;
          w_state_n = S_IDLE;
        end else begin
          w_baud_n = r_baud + BW'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_baud_n  = '0;
        w_tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_mmio.sv
// Directed bench for mips_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=8, LED_W=16) with a
// passive serial receiver that collects decoded bytes.
module tb_mips_mmio;

  localparam logic [31:0] A_LED = 32'h8000_0000;
  localparam logic [31:0] A_TMR = 32'h8000_0004;
  localparam logic [31:0] A_TXD = 32'h8000_0008;
  localparam logic [31:0] A_STS = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_wr_ena;
  logic [31:0] ram_addr, ram_wr_data, ram_rd_data;
  logic        ram_wr_ena;
  logic [15:0] leds;
  logic        uart_tx;

  int n_vec = 0;
  int n_err = 0;

  mips_mmio #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .LED_W(16)) dut (
    .clk(clk), .rstb(rstb),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
    .mem_rd_data(mem_rd_data),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_ena(ram_wr_ena),
    .ram_rd_data(ram_rd_data),
    .leds(leds), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // Serial receiver: s counts cycles from the first low sample; bit b is taken at s=6+4b.
  logic [7:0] rx_sh;
  logic       rx_act;
  int         rx_cnt;
  logic [7:0] rx_q [$];

  always @(negedge clk) begin
    if (rstb !== 1'b1) begin
      rx_act <= 1'b0;
      rx_cnt <= 0;
    end else if (!rx_act) begin
      if (uart_tx === 1'b0) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if ((rx_cnt % 4) == 2 && rx_cnt >= 6 && rx_cnt <= 34) rx_sh <= {uart_tx, rx_sh[7:1]};
      if (rx_cnt == 39) begin
        rx_act <= 1'b0;
        rx_q.push_back(rx_sh);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    mem_addr    = addr;
    mem_wr_data = data;
    mem_wr_ena  = 1'b1;
    tick();
    mem_wr_ena  = 1'b0;
  endtask

  initial begin
    logic [7:0]  frame;
    logic [31:0] got;
    logic        want_bit;
    int          lows;

    rstb = 1'b0; mem_addr = 32'd0; mem_wr_data = 32'd0; mem_wr_ena = 1'b0;
    ram_rd_data = 32'd0;
    tick();
    tick();

    // Timer counts cycles from the reset release
    rstb = 1'b1;
    mem_addr = A_TMR;
    #1 chk("timer_k0", mem_rd_data, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("timer_k", mem_rd_data, 32'(k));
    end

    chk("rst_leds", {16'd0, leds}, 32'd0);
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    mem_addr = A_STS;
    #1 chk("rst_status", mem_rd_data, 32'h0000_0002);

    wr(A_TMR, 32'hFFFF_FFFE);
    chk("timer_load", mem_rd_data, 32'hFFFF_FFFE);
    tick();
    chk("timer_max", mem_rd_data, 32'hFFFF_FFFF);
    tick();
    chk("timer_wrap", mem_rd_data, 32'h0000_0000);

    // RAM passthrough
    mem_addr = 32'h0000_0040; mem_wr_data = 32'h1234_5678; mem_wr_ena = 1'b1;
    #1;
    chk("ram_we", {31'd0, ram_wr_ena}, 32'd1);
    chk("ram_addr", ram_addr, 32'h0000_0040);
    chk("ram_wdata", ram_wr_data, 32'h1234_5678);
    tick();
    mem_wr_ena = 1'b0;
    #1 chk("ram_we_off", {31'd0, ram_wr_ena}, 32'd0);
    ram_rd_data = 32'hCAFE_F00D;
    #1 chk("ram_rdata", mem_rd_data, 32'hCAFE_F00D);

    // LED register and decoder holes
    mem_addr = A_LED; mem_wr_data = 32'hFFFF_A5A5; mem_wr_ena = 1'b1;
    #1 chk("led_ram_we", {31'd0, ram_wr_ena}, 32'd0);
    tick();
    mem_wr_ena = 1'b0;
    #1;
    chk("leds", {16'd0, leds}, 32'h0000_A5A5);
    chk("led_read", mem_rd_data, 32'h0000_A5A5);
    mem_addr = 32'h8000_0010;
    #1 chk("hole_read", mem_rd_data, 32'd0);
    mem_addr = A_TXD;
    #1 chk("txd_read", mem_rd_data, 32'd0);
    wr(32'h8000_0010, 32'h0000_1111);
    mem_addr = A_LED;
    #1 chk("hole_write", mem_rd_data, 32'h0000_A5A5);

    // Single frame 0x55
    wr(A_TXD, 32'h0000_0055);
    mem_addr = A_STS;
    #1 chk("sts_one", mem_rd_data, 32'h0000_0100);
    tick();
    frame = 8'h55;
    for (int j = 0; j <= 40; j++) begin
      if (j < 4)       want_bit = 1'b0;
      else if (j < 36) want_bit = frame[(j - 4) / 4];
      else             want_bit = 1'b1;
      chk("frame_tx", {31'd0, uart_tx}, {31'd0, want_bit});
      chk("frame_busy", {31'd0, mem_rd_data[2]}, (j < 40) ? 32'd1 : 32'd0);
      tick();
    end
    chk("rx_one_n", 32'(rx_q.size()), 32'd1);
    got = (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD_BEEF;
    chk("rx_one", got, 32'h0000_0055);
    rx_q.delete();

    // Ten pushes back to back: byte 10 hits a full FIFO
    for (int i = 0; i < 10; i++) wr(A_TXD, 32'h31 + 32'(i));
    mem_addr = A_STS;
    #1 chk("sts_full_ovf", mem_rd_data, 32'h0000_080D);
    wr(A_STS, 32'd0);
    chk("sts_ovf_clr", mem_rd_data, 32'h0000_0805);
    for (int c = 0; c < 1000 && rx_q.size() < 9; c++) tick();
    chk("rx_burst_n", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      got = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD_BEEF;
      chk("rx_burst", got, 32'h31 + 32'(i));
    end
    repeat (60) tick();
    chk("rx_no_tenth", 32'(rx_q.size()), 32'd9);
    chk("sts_drained", mem_rd_data, 32'h0000_0002);
    rx_q.delete();

    // Reset in the middle of a DATA phase with a second byte queued
    wr(A_TXD, 32'h0000_00A3);
    wr(A_TXD, 32'h0000_003C);
    repeat (8) tick();
    rstb = 1'b0;
    tick();
    mem_addr = A_STS;
    #1;
    chk("midrst_tx", {31'd0, uart_tx}, 32'd1);
    chk("midrst_sts", mem_rd_data, 32'h0000_0002);
    rstb = 1'b1;
    lows = 0;
    repeat (100) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    chk("midrst_quiet", 32'(lows), 32'd0);
    chk("midrst_rx", 32'(rx_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
